// File: rtl/video_seq_pkg.sv
// Shared encodings for the video sequencer: slot modes, strobe offsets
// relative to a slot/fetch base, and the ISA arbiter state type.
package video_seq_pkg;

  typedef enum logic [1:0] {
    SLOT_1    = 2'd0,
    SLOT_2    = 2'd1,
    SLOT_4    = 2'd2,
    SLOT_RSVD = 2'd3
  } slot_mode_e;

  localparam int OFF_VRAM_FIRST = 1;
  localparam int OFF_VRAM_A0    = 2;
  localparam int OFF_VRAM_LAST  = 3;
  localparam int OFF_CHAR       = 2;
  localparam int OFF_ATT        = 3;
  localparam int OFF_DISP       = 4;

  typedef enum logic {
    ISA_IDLE = 1'b0,
    ISA_BUSY = 1'b1
  } isa_state_e;

endpackage

// File: rtl/video_isa_arbiter.sv
// ISA access arbiter: grants a request only when the whole operation fits
// inside the current free window, then stays busy for the rest of the op.
module video_isa_arbiter
  import video_seq_pkg::*;
#(
  parameter int SEQ_BITS   = 5,
  parameter int ISA_OP_LEN = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SEQ_BITS-1:0] count_i,
  input  logic                window_i,
  input  logic                fits_i,
  input  logic                req_i,
  output logic                gnt_o,
  output logic                busy_o
);

  isa_state_e          state_q, state_d;
  logic [SEQ_BITS-1:0] end_q, end_d;

  // The op ends on an absolute count, so no separate down-counter is needed.
  always_comb begin
    state_d = state_q;
    end_d   = end_q;
    gnt_o   = 1'b0;
    unique case (state_q)
      ISA_IDLE: begin
        gnt_o = req_i && window_i && fits_i;
        if (gnt_o && (ISA_OP_LEN > 1)) begin
          state_d = ISA_BUSY;
          end_d   = count_i + SEQ_BITS'(ISA_OP_LEN - 1);
        end
      end
      ISA_BUSY: begin
        if (count_i == end_q) state_d = ISA_IDLE;
      end
      default: state_d = ISA_IDLE;
    endcase
    busy_o = gnt_o || (state_q == ISA_BUSY);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ISA_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    end_q <= end_d;
  end

endmodule

// File: rtl/video_sequencer.sv
// Free-running character-clock sequencer: decodes CRTC/VRAM fetch strobes from
// a period counter and opens ISA access windows between fetch bursts.
module video_sequencer
  import video_seq_pkg::*;
#(
  parameter int SEQ_BITS   = 5,
  parameter int ISA_OP_LEN = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          slot_mode,
  output logic [SEQ_BITS-1:0] clk_seq,
  output logic                lclk,
  output logic                hclk,
  output logic                crtc_clk,
  output logic                vram_read,
  output logic                vram_read_a0,
  output logic                vram_read_char,
  output logic                vram_read_att,
  output logic                charrom_read,
  output logic                disp_pipeline,
  output logic [1:0]          slot_idx,
  output logic                isa_op_enable,
  input  logic                isa_req,
  output logic                isa_gnt,
  output logic                isa_busy
);

  typedef logic [SEQ_BITS:0] ext_t;
  localparam ext_t HALF  = ext_t'(2 ** (SEQ_BITS - 1));
  localparam ext_t QUART = ext_t'(2 ** (SEQ_BITS - 2));

  logic [SEQ_BITS-1:0] count_q, count_d;
  slot_mode_e          mode_q, mode_d;

  // Mode is only picked up on the last count so a period never mixes modes.
  always_comb begin
    count_d = count_q + 1'b1;
    mode_d  = mode_q;
    if (count_q == '1) begin
      mode_d = (slot_mode_e'(slot_mode) == SLOT_RSVD) ? SLOT_1 : slot_mode_e'(slot_mode);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      mode_q  <= SLOT_1;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  ext_t       cnt_e, off_half, off_quart, fetch_off, fetch_len, act_off;
  logic       win_r, fits_r;
  logic [1:0] idx_r;

  always_comb begin
    cnt_e     = {1'b0, count_q};
    off_half  = cnt_e & (HALF - 1'b1);
    off_quart = cnt_e & (QUART - 1'b1);
    fetch_off = (mode_q == SLOT_4) ? off_quart : off_half;
    fetch_len = (mode_q == SLOT_4) ? QUART : HALF;
    act_off   = cnt_e;
    idx_r     = 2'b00;
    unique case (mode_q)
      SLOT_2: begin
        act_off = off_half;
        idx_r   = {count_q[SEQ_BITS-1], 1'b0};
      end
      SLOT_4: begin
        act_off = off_quart;
        idx_r   = count_q[SEQ_BITS-1 -: 2];
      end
      default: ;
    endcase
    win_r  = (fetch_off > ext_t'(OFF_DISP)) && (fetch_off < fetch_len - 1'b1);
    fits_r = (fetch_off > ext_t'(OFF_DISP)) && (fetch_off + ext_t'(ISA_OP_LEN) < fetch_len);
  end

  logic gnt_r, busy_r;

  video_isa_arbiter #(
    .SEQ_BITS  (SEQ_BITS),
    .ISA_OP_LEN(ISA_OP_LEN)
  ) u_isa_arb (
    .clk_i   (clk),
    .rst_i   (reset),
    .count_i (count_q),
    .window_i(win_r),
    .fits_i  (fits_r),
    .req_i   (isa_req),
    .gnt_o   (gnt_r),
    .busy_o  (busy_r)
  );

  // Count 0 would otherwise decode live strobes while reset is held.
  assign clk_seq        = count_q;
  assign slot_idx       = idx_r;
  assign lclk           = ~reset && (cnt_e == '0);
  assign hclk           = ~reset && (off_half == '0);
  assign crtc_clk       = ~reset && (act_off == '0);
  assign vram_read      = ~reset && (fetch_off >= ext_t'(OFF_VRAM_FIRST)) &&
                          (fetch_off <= ext_t'(OFF_VRAM_LAST));
  assign vram_read_a0   = ~reset && (fetch_off == ext_t'(OFF_VRAM_A0));
  assign vram_read_char = ~reset && (act_off == ext_t'(OFF_CHAR));
  assign vram_read_att  = ~reset && (act_off == ext_t'(OFF_ATT));
  assign charrom_read   = ~reset && (act_off == ext_t'(OFF_ATT));
  assign disp_pipeline  = ~reset && (act_off == ext_t'(OFF_DISP));
  assign isa_op_enable  = ~reset && win_r;
  assign isa_gnt        = ~reset && gnt_r;
  assign isa_busy       = ~reset && busy_r;

endmodule

// File: tb/tb_video_sequencer.sv
// Directed bench for video_sequencer: strobe decode table plus hand-written
// ISA grant, mode-change and reset sequences on 5-bit and 6-bit instances.
`timescale 1ns/1ps
module tb_video_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] slot_mode, slot_mode6;
  logic       isa_req, isa_req6;

  logic [4:0] clk_seq;
  logic lclk, hclk, crtc_clk, vram_read, vram_read_a0, vram_read_char;
  logic vram_read_att, charrom_read, disp_pipeline, isa_op_enable, isa_gnt, isa_busy;
  logic [1:0] slot_idx;

  logic [5:0] clk_seq6;
  logic lclk6, hclk6, crtc_clk6, vram_read6, vram_read_a06, vram_read_char6;
  logic vram_read_att6, charrom_read6, disp_pipeline6, isa_op_enable6, isa_gnt6, isa_busy6;
  logic [1:0] slot_idx6;

  always #5 clk = ~clk;

  video_sequencer #(.SEQ_BITS(5), .ISA_OP_LEN(3)) dut (
    .clk(clk), .reset(reset), .slot_mode(slot_mode), .clk_seq(clk_seq),
    .lclk(lclk), .hclk(hclk), .crtc_clk(crtc_clk), .vram_read(vram_read),
    .vram_read_a0(vram_read_a0), .vram_read_char(vram_read_char),
    .vram_read_att(vram_read_att), .charrom_read(charrom_read),
    .disp_pipeline(disp_pipeline), .slot_idx(slot_idx),
    .isa_op_enable(isa_op_enable), .isa_req(isa_req), .isa_gnt(isa_gnt),
    .isa_busy(isa_busy)
  );

  video_sequencer #(.SEQ_BITS(6), .ISA_OP_LEN(3)) dut6 (
    .clk(clk), .reset(reset), .slot_mode(slot_mode6), .clk_seq(clk_seq6),
    .lclk(lclk6), .hclk(hclk6), .crtc_clk(crtc_clk6), .vram_read(vram_read6),
    .vram_read_a0(vram_read_a06), .vram_read_char(vram_read_char6),
    .vram_read_att(vram_read_att6), .charrom_read(charrom_read6),
    .disp_pipeline(disp_pipeline6), .slot_idx(slot_idx6),
    .isa_op_enable(isa_op_enable6), .isa_req(isa_req6), .isa_gnt(isa_gnt6),
    .isa_busy(isa_busy6)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] mode;
    int         cnt;
    logic [9:0] exp;   // lclk hclk crtc vr a0 char att crom disp win
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[25];

  function automatic logic [9:0] strobes5();
    return {lclk, hclk, crtc_clk, vram_read, vram_read_a0, vram_read_char,
            vram_read_att, charrom_read, disp_pipeline, isa_op_enable};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic wait_seq(input bit six, input int c);
    bit hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((six ? int'(clk_seq6) : int'(clk_seq)) == c) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_seq: count %0d never reached (six=%0d)", c, six);
    end
  endtask

  // Leaves the bench at count 0 of a period running in mode m.
  task automatic set_mode(input logic [1:0] m);
    slot_mode = m;
    wait_seq(1'b0, 31);
    wait_seq(1'b0, 0);
  endtask

  initial begin
    vecs[0]  = '{2'd1, 0,  10'b1110000000, 2'd0};
    vecs[1]  = '{2'd1, 1,  10'b0001000000, 2'd0};
    vecs[2]  = '{2'd1, 2,  10'b0001110000, 2'd0};
    vecs[3]  = '{2'd1, 3,  10'b0001001100, 2'd0};
    vecs[4]  = '{2'd1, 4,  10'b0000000010, 2'd0};
    vecs[5]  = '{2'd1, 5,  10'b0000000001, 2'd0};
    vecs[6]  = '{2'd1, 14, 10'b0000000001, 2'd0};
    vecs[7]  = '{2'd1, 15, 10'b0000000000, 2'd0};
    vecs[8]  = '{2'd1, 16, 10'b0110000000, 2'd2};
    vecs[9]  = '{2'd1, 20, 10'b0000000010, 2'd2};
    vecs[10] = '{2'd1, 30, 10'b0000000001, 2'd2};
    vecs[11] = '{2'd1, 31, 10'b0000000000, 2'd2};
    vecs[12] = '{2'd0, 16, 10'b0100000000, 2'd0};
    vecs[13] = '{2'd0, 17, 10'b0001000000, 2'd0};
    vecs[14] = '{2'd0, 18, 10'b0001100000, 2'd0};
    vecs[15] = '{2'd0, 20, 10'b0000000000, 2'd0};
    vecs[16] = '{2'd0, 21, 10'b0000000001, 2'd0};
    vecs[17] = '{2'd2, 4,  10'b0000000010, 2'd0};
    vecs[18] = '{2'd2, 8,  10'b0010000000, 2'd1};
    vecs[19] = '{2'd2, 10, 10'b0001110000, 2'd1};
    vecs[20] = '{2'd2, 13, 10'b0000000001, 2'd1};
    vecs[21] = '{2'd2, 15, 10'b0000000000, 2'd1};
    vecs[22] = '{2'd2, 24, 10'b0010000000, 2'd3};
    vecs[23] = '{2'd3, 16, 10'b0100000000, 2'd0};
    vecs[24] = '{2'd3, 2,  10'b0001110000, 2'd0};

    reset = 1'b1; slot_mode = 2'd0; slot_mode6 = 2'd2; isa_req = 1'b0; isa_req6 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_seq", clk_seq, 0);
    check("rst_strobes", strobes5(), 0);
    check("rst_gnt_busy", {isa_gnt, isa_busy}, 0);
    check("rst_gnt6_busy6", {isa_gnt6, isa_busy6}, 0);
    reset = 1'b0;
    #1;
    check("rel_lclk", lclk, 1);
    check("rel_clk_seq", clk_seq, 0);
    @(negedge clk);
    check("first_edge_seq", clk_seq, 1);
    check("first_edge_lclk", lclk, 0);

    // Strobe decode table
    for (int i = 0; i < 25; i++) begin
      set_mode(vecs[i].mode);
      if (vecs[i].cnt != 0) wait_seq(1'b0, vecs[i].cnt);
      check($sformatf("vec%0d_strobes", i), strobes5(), vecs[i].exp);
      check($sformatf("vec%0d_idx", i), slot_idx, vecs[i].idx);
      check($sformatf("vec%0d_gnt", i), isa_gnt, 0);
    end

    // Request held from count 0 in mode 0
    set_mode(2'd0);
    isa_req = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c != 0) @(negedge clk);
      check($sformatf("hold_seq_c%0d", c), clk_seq, c);
      check($sformatf("hold_gnt_c%0d", c), isa_gnt,
            (c == 5 || c == 8 || c == 11 || c == 21 || c == 24 || c == 27) ? 1 : 0);
      check($sformatf("hold_busy_c%0d", c), isa_busy,
            ((c >= 5 && c <= 13) || (c >= 21 && c <= 29)) ? 1 : 0);
    end

    // Mode 0 -> 2 written mid-period
    wait_seq(1'b0, 10);
    slot_mode = 2'd2;
    for (int c = 10; c < 32; c++) begin
      if (c != 10) @(negedge clk);
      check($sformatf("mchg_crtc_c%0d", c), crtc_clk, 0);
      check($sformatf("mchg_gnt_c%0d", c), isa_gnt,
            (c == 11 || c == 21 || c == 24 || c == 27) ? 1 : 0);
    end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      check($sformatf("m2_seq_c%0d", c), clk_seq, c);
      check($sformatf("m2_crtc_c%0d", c), crtc_clk, (c % 8 == 0) ? 1 : 0);
      check($sformatf("m2_gnt_busy_c%0d", c), {isa_gnt, isa_busy}, 0);
    end

    // SEQ_BITS=6 in mode 2
    wait_seq(1'b1, 0);
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      check($sformatf("s6_win_c%0d", c), isa_op_enable6, (c >= 5 && c <= 14) ? 1 : 0);
      check($sformatf("s6_gnt_c%0d", c), isa_gnt6, (c == 5 || c == 8 || c == 11) ? 1 : 0);
      check($sformatf("s6_busy_c%0d", c), isa_busy6, (c >= 5 && c <= 13) ? 1 : 0);
    end

    // Reset pulsed during an ISA operation
    set_mode(2'd0);
    wait_seq(1'b0, 6);
    check("abort_busy_before", isa_busy, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy_async", isa_busy, 0);
    check("abort_seq_async", clk_seq, 0);
    @(negedge clk);
    check("abort_held_lclk", lclk, 0);
    reset = 1'b0;
    #1;
    check("abort_rel_lclk", lclk, 1);
    check("abort_rel_seq", clk_seq, 0);
    check("abort_rel_gnt_busy", {isa_gnt, isa_busy}, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("abort_seq_c%0d", c), clk_seq, c);
      check($sformatf("abort_gnt_c%0d", c), isa_gnt, (c == 5) ? 1 : 0);
      check($sformatf("abort_busy_c%0d", c), isa_busy, (c == 5) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
